// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the pedestrian crossing controller.
//   state_t : one-hot phase encoding of the controller
//   lamp_t  : lamp vector {g_car, y_car, r_car, g_pedes, r_pedes}
//   LAMP_*  : lamp pattern shown in each phase, plus the safe all-red pattern
package traffic_pkg;

  typedef enum logic [3:0] {
    CAR_GO    = 4'b0001,
    CAR_WARN  = 4'b0010,
    PED_GO    = 4'b0100,
    PED_CLEAR = 4'b1000
  } state_t;

  typedef struct packed {
    logic g_car;
    logic y_car;
    logic r_car;
    logic g_pedes;
    logic r_pedes;
  } lamp_t;

  localparam lamp_t LAMP_CAR_GO    = 5'b10001;
  localparam lamp_t LAMP_CAR_WARN  = 5'b01001;
  localparam lamp_t LAMP_PED_GO    = 5'b00110;
  localparam lamp_t LAMP_PED_CLEAR = 5'b00101;
  // Shown while the state register holds a non-one-hot value.
  localparam lamp_t LAMP_SAFE      = 5'b00101;

endpackage

// File: rtl/traffic.sv
// traffic: Moore controller for a pedestrian crossing.
//   CLK, RST      : clock, synchronous active-high reset
//   TC_10, TC_2   : terminal-count pulses of the external long/short timers
//   RST_Q         : registered restart request to both timers; high on the
//                   reset edge and for the first cycle of every new phase
//   G_CAR/Y_CAR/R_CAR, G_PEDES/R_PEDES : lamp drives, pure state decodes
//
// Phase sequence: CAR_GO -(TC_10)-> CAR_WARN -(TC_2)-> PED_GO -(TC_10)->
// PED_CLEAR -(TC_2)-> CAR_GO. Only the TC named for the current phase is
// looked at, and both TCs are ignored while RST_Q is high because the
// timers have not yet been cleared and may still show a stale count.
module traffic
  import traffic_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic TC_2,
  input  logic TC_10,
  output logic RST_Q,
  output logic G_CAR,
  output logic Y_CAR,
  output logic R_CAR,
  output logic G_PEDES,
  output logic R_PEDES
);

  state_t state_q;
  state_t state_d;
  logic   trans;
  lamp_t  lamps;

  // State register; RST_Q marks the first cycle of each phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CAR_GO;
      RST_Q   <= 1'b1;
    end else begin
      state_q <= state_d;
      RST_Q   <= trans;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    trans   = 1'b0;
    case (state_q)
      CAR_GO: begin
        if (!RST_Q && TC_10) begin
          state_d = CAR_WARN;
          trans   = 1'b1;
        end
      end
      CAR_WARN: begin
        if (!RST_Q && TC_2) begin
          state_d = PED_GO;
          trans   = 1'b1;
        end
      end
      PED_GO: begin
        if (!RST_Q && TC_10) begin
          state_d = PED_CLEAR;
          trans   = 1'b1;
        end
      end
      PED_CLEAR: begin
        if (!RST_Q && TC_2) begin
          state_d = CAR_GO;
          trans   = 1'b1;
        end
      end
      default: begin
        // Non-one-hot value: recover to CAR_GO and restart the timers.
        state_d = CAR_GO;
        trans   = 1'b1;
      end
    endcase
  end

  // Lamp decode.
  always_comb begin
    lamps = LAMP_SAFE;
    case (state_q)
      CAR_GO:    lamps = LAMP_CAR_GO;
      CAR_WARN:  lamps = LAMP_CAR_WARN;
      PED_GO:    lamps = LAMP_PED_GO;
      PED_CLEAR: lamps = LAMP_PED_CLEAR;
      default:   lamps = LAMP_SAFE;
    endcase
  end

  assign G_CAR   = lamps.g_car;
  assign Y_CAR   = lamps.y_car;
  assign R_CAR   = lamps.r_car;
  assign G_PEDES = lamps.g_pedes;
  assign R_PEDES = lamps.r_pedes;

endmodule

// File: tb/tb_traffic.sv
// tb_traffic: self-checking bench for traffic. A phase-level reference
// model predicts {RST_Q, lamps} after every edge; modulo-10 / modulo-2
// timer models close the loop for the duration checks.
module tb_traffic;

  logic CLK;
  logic RST;
  logic TC_2;
  logic TC_10;
  logic RST_Q;
  logic G_CAR;
  logic Y_CAR;
  logic R_CAR;
  logic G_PEDES;
  logic R_PEDES;

  traffic dut (
    .CLK    (CLK),
    .RST    (RST),
    .TC_2   (TC_2),
    .TC_10  (TC_10),
    .RST_Q  (RST_Q),
    .G_CAR  (G_CAR),
    .Y_CAR  (Y_CAR),
    .R_CAR  (R_CAR),
    .G_PEDES(G_PEDES),
    .R_PEDES(R_PEDES)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ph: 0=car go, 1=car warn, 2=ped go, 3=ped clear. Even phases wait on
  // the long timer, odd phases on the short one.
  int   ph = 0;
  logic rq = 1'b1;

  function automatic logic [4:0] lamp_of(input int p);
    case (p)
      0:       return 5'b10001;
      1:       return 5'b01001;
      2:       return 5'b00110;
      default: return 5'b00101;
    endcase
  endfunction

  // ---------------- timer models ----------------
  int   c10 = 0;
  int   c2 = 0;
  logic t10 = 1'b0;
  logic t2 = 1'b0;
  bit   closed = 1'b0;

  // ---------------- phase length measurement ----------------
  bit       measure = 1'b0;
  int       run = 0;
  logic [4:0] prev_l = 5'b0;

  function automatic int len_of(input logic [4:0] l);
    return (l == 5'b10001 || l == 5'b00110) ? 12 : 4;
  endfunction

  function automatic logic [4:0] lamps_now();
    return {G_CAR, Y_CAR, R_CAR, G_PEDES, R_PEDES};
  endfunction

  // ---------------- driver: one clock edge ----------------
  task automatic step();
    logic       tc_sel;
    logic       rst_was;
    int         n10, n2;
    logic       nt10, nt2;
    logic [5:0] e;
    logic [4:0] obs;

    rst_was = RST;
    tc_sel  = (ph % 2 == 0) ? TC_10 : TC_2;
    if (RST) begin
      ph = 0;
      rq = 1'b1;
    end else if (!rq && tc_sel) begin
      ph = (ph + 1) % 4;
      rq = 1'b1;
    end else begin
      rq = 1'b0;
    end
    exp_q.push_back({rq, lamp_of(ph)});

    // Timers clear on a sampled restart request; TC is a registered pulse.
    n10  = RST_Q ? 0 : (c10 + 1) % 10;
    nt10 = !RST_Q && (c10 == 9);
    n2   = RST_Q ? 0 : (c2 + 1) % 2;
    nt2  = !RST_Q && (c2 == 1);

    @(posedge CLK);
    #1;
    c10 = n10; t10 = nt10;
    c2  = n2;  t2  = nt2;
    if (closed) begin
      TC_10 = t10;
      TC_2  = t2;
    end

    obs = lamps_now();
    e = exp_q.pop_front();
    chk("rst_q", 8'(RST_Q), 8'(e[5]));
    chk("lamps", 8'(obs), 8'(e[4:0]));
    chk("one_car", 8'(G_CAR) + 8'(Y_CAR) + 8'(R_CAR), 8'd1);
    chk("one_ped", 8'(G_PEDES) + 8'(R_PEDES), 8'd1);
    chk("no_dual_green", 8'(G_CAR & G_PEDES), 8'd0);

    if (measure) begin
      if (rst_was) begin
        run = 1;
        prev_l = obs;
      end else if (obs == prev_l) begin
        run++;
      end else begin
        chk("phase_len", 8'(run), 8'(len_of(prev_l)));
        run = 1;
        prev_l = obs;
      end
    end
  endtask

  task automatic pulse_tc(input logic p10, input logic p2);
    TC_10 = p10; TC_2 = p2;
    step();
    TC_10 = 1'b0; TC_2 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Run closed loop until the given lamp pattern has been shown for k cycles.
  task automatic run_until(input logic [4:0] l, input int k, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (lamps_now() == l && run == k) found = 1'b1;
    end
    chk(tag, 8'(found), 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; TC_10 = 1'b0; TC_2 = 1'b0;

    // 1: held reset with toggling TCs.
    for (int i = 0; i < 11; i++) begin
      TC_10 = i[0];
      TC_2  = ~i[0];
      step();
    end
    RST = 1'b0; TC_10 = 1'b0; TC_2 = 1'b0;
    step();
    chk("t1_release_rst_q", 8'(RST_Q), 8'd0);

    // 2: CAR_GO ignores TC_2.
    TC_2 = 1'b1;
    idle(50);
    TC_2 = 1'b0;
    chk("t2_still_car_go", 8'(lamps_now()), 8'b10001);

    // 3: directed pulses around the full cycle.
    pulse_tc(1'b1, 1'b0);
    chk("t3_warn", 8'(lamps_now()), 8'b01001);
    step();
    pulse_tc(1'b0, 1'b1);
    chk("t3_ped_go", 8'(lamps_now()), 8'b00110);
    step();
    pulse_tc(1'b1, 1'b0);
    chk("t3_ped_clear", 8'(lamps_now()), 8'b00101);
    step();
    pulse_tc(1'b0, 1'b1);
    chk("t3_car_go", 8'(lamps_now()), 8'b10001);
    step();

    // 4: both TCs together in CAR_GO, then TCs held during RST_Q=1.
    TC_10 = 1'b1; TC_2 = 1'b1;
    step();                  // -> CAR_WARN, RST_Q=1
    chk("t4_warn_only", 8'(lamps_now()), 8'b01001);
    step();                  // masked
    chk("t4_masked_warn", 8'(lamps_now()), 8'b01001);
    step();                  // TC_2 honoured -> PED_GO
    TC_2 = 1'b0;
    step();                  // TC_10 high while RST_Q=1: masked
    chk("t4_masked_ped", 8'(lamps_now()), 8'b00110);
    TC_10 = 1'b0;
    idle(3);
    chk("t4_stay_ped", 8'(lamps_now()), 8'b00110);

    // 5: closed loop from a reset edge over three full cycles.
    closed = 1'b1;
    measure = 1'b1;
    pulse_reset();
    idle(100);

    // 6: reset mid PED_GO and mid PED_CLEAR, each followed by a full CAR_GO.
    run_until(5'b00110, 5, "t6_reach_ped_go");
    pulse_reset();
    chk("t6a_car_go", 8'({RST_Q, lamps_now()}), 8'b110001);
    idle(40);
    run_until(5'b00101, 2, "t6_reach_ped_clear");
    pulse_reset();
    chk("t6b_car_go", 8'({RST_Q, lamps_now()}), 8'b110001);
    idle(40);

    // Randomised open-loop stimulus including sporadic resets.
    closed = 1'b0;
    measure = 1'b0;
    for (int i = 0; i < 400; i++) begin
      TC_10 = ($urandom_range(0, 3) == 0);
      TC_2  = ($urandom_range(0, 1) == 1);
      RST   = ($urandom_range(0, 31) == 0);
      step();
    end
    RST = 1'b0;

    chk("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
